// File: rtl/mem_port_responder.sv
// Dual-channel (instruction/data) memory responder sharing one word array.
// Each channel accepts a held request, waits a fixed latency, then pulses resp for one cycle.
module mem_port_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int INST_LATENCY = 2,
    parameter int DATA_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    // Instruction channel
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    // Data channel
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    // FSM state observation (encoding of state_e)
    output logic [1:0]  inst_state_dbg,
    output logic [1:0]  data_state_dbg
);

    // Handshake: the initiator raises read/write and holds it; the request is
    // taken on the first rising edge seen in IDLE. Completion is the one-cycle
    // resp pulse, during which rdata is valid. There is no abort: once taken,
    // the captured request completes regardless of what the inputs do.

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] INST_LOAD = 4'(INST_LATENCY - 1);
    localparam logic [3:0] DATA_LOAD = 4'(DATA_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Instruction channel state
    state_e             inst_state_q, inst_state_d;
    logic [3:0]         inst_cnt_q, inst_cnt_d;
    logic [IDX_W-1:0]   inst_idx_q, inst_idx_d;
    logic [31:0]        inst_rdata_q, inst_rdata_d;
    logic               inst_go_resp;
    logic [IDX_W-1:0]   inst_eff_idx;

    // Data channel state
    state_e             data_state_q, data_state_d;
    logic [3:0]         data_cnt_q, data_cnt_d;
    logic [IDX_W-1:0]   data_idx_q, data_idx_d;
    logic               data_wr_q, data_wr_d;
    logic [3:0]         data_mbe_q, data_mbe_d;
    logic [31:0]        data_wdata_q, data_wdata_d;
    logic [31:0]        data_rdata_q, data_rdata_d;
    logic               data_go_resp;
    logic [IDX_W-1:0]   data_eff_idx;
    logic               data_eff_wr;
    logic [3:0]         data_eff_mbe;
    logic [31:0]        data_eff_wdata;

    logic               mem_we;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:IDX_W+2], inst_addr[1:0],
                                data_addr[31:IDX_W+2], data_addr[1:0]};

    always_comb begin
        inst_state_d = inst_state_q;
        inst_cnt_d   = inst_cnt_q;
        inst_idx_d   = inst_idx_q;
        inst_rdata_d = inst_rdata_q;
        inst_go_resp = 1'b0;
        inst_eff_idx = inst_idx_q;
        unique case (inst_state_q)
            ST_IDLE: begin
                if (inst_read) begin
                    inst_idx_d = inst_addr[IDX_W+1:2];
                    inst_cnt_d = INST_LOAD;
                    if (INST_LATENCY == 1) begin
                        inst_state_d = ST_RESP;
                        inst_go_resp = 1'b1;
                        inst_eff_idx = inst_addr[IDX_W+1:2];
                    end else begin
                        inst_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Leave WAIT on the edge the counter reaches zero.
                inst_cnt_d = inst_cnt_q - 4'd1;
                if (inst_cnt_q <= 4'd1) begin
                    inst_cnt_d   = 4'd0;
                    inst_state_d = ST_RESP;
                    inst_go_resp = 1'b1;
                end
            end
            ST_RESP: inst_state_d = ST_IDLE;
            default: inst_state_d = ST_IDLE;
        endcase
        // Array read sees the pre-edge contents, so a same-edge data write is not visible.
        if (inst_go_resp) begin
            inst_rdata_d = mem_q[inst_eff_idx];
        end
    end

    always_comb begin
        data_state_d   = data_state_q;
        data_cnt_d     = data_cnt_q;
        data_idx_d     = data_idx_q;
        data_wr_d      = data_wr_q;
        data_mbe_d     = data_mbe_q;
        data_wdata_d   = data_wdata_q;
        data_rdata_d   = data_rdata_q;
        data_go_resp   = 1'b0;
        data_eff_idx   = data_idx_q;
        data_eff_wr    = data_wr_q;
        data_eff_mbe   = data_mbe_q;
        data_eff_wdata = data_wdata_q;
        unique case (data_state_q)
            ST_IDLE: begin
                if (data_read || data_write) begin
                    data_idx_d   = data_addr[IDX_W+1:2];
                    data_wr_d    = data_write;
                    data_mbe_d   = data_mbe;
                    data_wdata_d = data_wdata;
                    data_cnt_d   = DATA_LOAD;
                    if (DATA_LATENCY == 1) begin
                        data_state_d   = ST_RESP;
                        data_go_resp   = 1'b1;
                        data_eff_idx   = data_addr[IDX_W+1:2];
                        data_eff_wr    = data_write;
                        data_eff_mbe   = data_mbe;
                        data_eff_wdata = data_wdata;
                    end else begin
                        data_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                data_cnt_d = data_cnt_q - 4'd1;
                if (data_cnt_q <= 4'd1) begin
                    data_cnt_d   = 4'd0;
                    data_state_d = ST_RESP;
                    data_go_resp = 1'b1;
                end
            end
            ST_RESP: data_state_d = ST_IDLE;
            default: data_state_d = ST_IDLE;
        endcase
        if (data_go_resp) begin
            data_rdata_d = data_eff_wr ? 32'd0 : mem_q[data_eff_idx];
        end
    end

    // Commit is gated by reset_n so nothing lands while reset is asserted.
    assign mem_we = data_go_resp && data_eff_wr && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_state_q <= ST_IDLE;
            inst_cnt_q   <= 4'd0;
            inst_idx_q   <= '0;
            inst_rdata_q <= 32'd0;
            data_state_q <= ST_IDLE;
            data_cnt_q   <= 4'd0;
            data_idx_q   <= '0;
            data_wr_q    <= 1'b0;
            data_mbe_q   <= 4'd0;
            data_wdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            inst_state_q <= inst_state_d;
            inst_cnt_q   <= inst_cnt_d;
            inst_idx_q   <= inst_idx_d;
            inst_rdata_q <= inst_rdata_d;
            data_state_q <= data_state_d;
            data_cnt_q   <= data_cnt_d;
            data_idx_q   <= data_idx_d;
            data_wr_q    <= data_wr_d;
            data_mbe_q   <= data_mbe_d;
            data_wdata_q <= data_wdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_eff_mbe[i]) begin
                    mem_q[data_eff_idx][8*i +: 8] <= data_eff_wdata[8*i +: 8];
                end
            end
        end
    end

    assign inst_resp      = (inst_state_q == ST_RESP);
    assign data_resp      = (data_state_q == ST_RESP);
    assign inst_rdata     = inst_rdata_q;
    assign data_rdata     = data_rdata_q;
    assign inst_state_dbg = inst_state_q;
    assign data_state_dbg = data_state_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench for mem_port_responder with default parameters
// (256 words, instruction latency 2, data latency 3).
module tb_mem_port_responder;

    logic        clk;
    logic        reset_n;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic [1:0]  inst_state_dbg;
    logic [1:0]  data_state_dbg;

    int num_checks;
    int num_errors;
    logic [31:0] exp_q[$];

    mem_port_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inst_read      (inst_read),
        .inst_addr      (inst_addr),
        .inst_resp      (inst_resp),
        .inst_rdata     (inst_rdata),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_mbe       (data_mbe),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_resp      (data_resp),
        .data_rdata     (data_rdata),
        .inst_state_dbg (inst_state_dbg),
        .data_state_dbg (data_state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends at posedge+1. Request inputs are scrambled right after
    // acceptance to show the captured values are what complete.
    task automatic data_txn(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mbe, input string tag);
        int n;
        logic [31:0] exp;
        data_read  = rd;
        data_write = wr;
        data_addr  = addr;
        data_wdata = wdata;
        data_mbe   = mbe;
        @(posedge clk); #1;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_addr  = $urandom;
        data_wdata = $urandom;
        data_mbe   = 4'($urandom_range(0, 15));
        n = 1;
        while (!data_resp && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd3);
        if (wr) begin
            check({tag, "_wr_rdata"}, data_rdata, 32'd0);
        end else begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            check({tag, "_rdata"}, data_rdata, exp);
        end
        @(posedge clk); #1;
        check({tag, "_pulse_w"}, {31'd0, data_resp}, 32'd0);
    endtask

    task automatic inst_txn(input logic [31:0] addr, input string tag);
        int n;
        logic [31:0] exp;
        inst_read = 1'b1;
        inst_addr = addr;
        @(posedge clk); #1;
        inst_read = 1'b0;
        inst_addr = $urandom;
        n = 1;
        while (!inst_resp && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_rdata"}, inst_rdata, exp);
        @(posedge clk); #1;
        check({tag, "_pulse_w"}, {31'd0, inst_resp}, 32'd0);
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        reset_n    = 1'b0;
        inst_read  = 1'b0;
        inst_addr  = 32'd0;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_mbe   = 4'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;

        @(posedge clk); #1;
        check("rst_inst_resp", {31'd0, inst_resp}, 32'd0);
        check("rst_data_resp", {31'd0, data_resp}, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_states", {28'd0, inst_state_dbg, data_state_dbg}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Full write then read back
        data_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
        exp_q.push_back(32'hDEADBEEF);
        data_txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd10");
        repeat (3) @(posedge clk);
        #1 check("rdata_hold", data_rdata, 32'hDEADBEEF);

        // Partial byte-enable write
        data_txn(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, "wr_mbe");
        exp_q.push_back(32'hDE22BE44);
        data_txn(1'b1, 1'b0, 32'h13, 32'h0, 4'h0, "rd_mbe");

        // Data write accepted one cycle before inst read; both complete on one edge
        data_write = 1'b1;
        data_addr  = 32'h10;
        data_wdata = 32'hCAFEF00D;
        data_mbe   = 4'hF;
        @(posedge clk); #1;
        data_write = 1'b0;
        inst_read  = 1'b1;
        inst_addr  = 32'h10;
        @(posedge clk); #1;
        inst_read  = 1'b0;
        @(posedge clk); #1;
        check("same_edge_resp", {30'd0, inst_resp, data_resp}, 32'd3);
        check("same_edge_inst_old", inst_rdata, 32'hDE22BE44);
        check("same_edge_data_rdata", data_rdata, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back(32'hCAFEF00D);
        inst_txn(32'h10, "inst_new");

        // Held inst_read: pulses every 3 cycles, each one cycle wide
        inst_read = 1'b1;
        inst_addr = 32'h10;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_resp_%0d", k), {31'd0, inst_resp}, {31'd0, (k % 3) == 1});
        end
        inst_read = 1'b0;
        check("b2b_rdata", inst_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Reset in the middle of a pending write
        data_txn(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, "wr20");
        data_write = 1'b1;
        data_addr  = 32'h20;
        data_wdata = 32'hFFFFFFFF;
        data_mbe   = 4'hF;
        @(posedge clk); #1;
        data_write = 1'b0;
        check("mid_rst_in_wait", {30'd0, data_state_dbg}, 32'd1);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("mid_rst_data_resp", {31'd0, data_resp}, 32'd0);
        check("mid_rst_state", {30'd0, data_state_dbg}, 32'd0);
        check("mid_rst_inst_rdata", inst_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_resp", {31'd0, data_resp}, 32'd0);
        end
        exp_q.push_back(32'h12345678);
        data_txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "rd20_kept");

        // Address wrap and read+write collision
        data_txn(1'b0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, "wr0");
        exp_q.push_back(32'h55AA55AA);
        data_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, "rd400_wrap");
        data_txn(1'b1, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, "rdwr30");
        exp_q.push_back(32'h0BADF00D);
        data_txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "rd30");

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
